// File: rtl/device_manager_mc.sv
`default_nettype none
// ============================================================================
// Module   : device_manager_mc
// Brief    : Memory-mapped multi-channel device front end with CPU passthrough.
//            Optional interrupt mask/irq enabled by macro DEVMGR_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module device_manager_mc #(
    parameter int                N_CH      = 4,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] BASE_ADDR = 'h0000_FF80
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   writeIn,
    input  logic                   readIn,
    input  logic [DATA_W-1:0]      addressIn,
    input  logic [DATA_W-1:0]      dataIn,
    input  logic [DATA_W-1:0]      memOutIn,
    input  logic [N_CH-1:0]        finish,
    output logic                   writeOut,
    output logic                   readOut,
    output logic [DATA_W-1:0]      memOutOut,
    output logic [N_CH*DATA_W-1:0] data,
    output logic [N_CH-1:0]        start
`ifdef DEVMGR_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam logic [DATA_W-1:0] c_ALIGN_MASK = ~DATA_W'(3);
    localparam logic [DATA_W-1:0] c_CH_SPAN    = DATA_W'(8 * N_CH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_off;
    logic              w_in_win;
    logic              w_hit_ch;
    logic              w_hit;
    logic [DATA_W-1:0] w_rdata;
    logic [N_CH-1:0]   w_sel_cmd;
    logic [N_CH-1:0]   w_sel_st;
    logic [N_CH-1:0]   w_busy;
    logic [N_CH-1:0]   w_done;
    logic [N_CH-1:0]   w_ovr;
    logic [DATA_W-1:0] w_ch_data [N_CH];

    // Byte-lane bits are dropped before decode so any alignment hits the word.
    assign w_addr   = addressIn & c_ALIGN_MASK;
    assign w_off    = w_addr - BASE_ADDR;
    assign w_in_win = (w_addr >= BASE_ADDR);
    assign w_hit_ch = w_in_win && (w_off < c_CH_SPAN);

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_ch
            state_t            state_q;
            logic [DATA_W-1:0] data_q;
            logic              ovr_q;
            logic              start_q;
            logic              w_cmd_wr;
            logic              w_st_wr;
            logic              w_st_rd;

            assign w_sel_cmd[k] = w_hit_ch && (w_off[6:3] == 4'(k)) && !w_off[2];
            assign w_sel_st[k]  = w_hit_ch && (w_off[6:3] == 4'(k)) &&  w_off[2];

            // A combined read+write strobe only performs the write side effects.
            assign w_cmd_wr = writeIn && w_sel_cmd[k];
            assign w_st_wr  = writeIn && w_sel_st[k];
            assign w_st_rd  = readIn && !writeIn && w_sel_st[k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    data_q  <= '0;
                    ovr_q   <= 1'b0;
                    start_q <= 1'b0;
                end else begin
                    start_q <= 1'b0;
                    case (state_q)
                        ST_IDLE, ST_DONE: begin
                            if (w_cmd_wr) begin
                                data_q  <= dataIn;
                                state_q <= ST_START;
                                start_q <= 1'b1;
                            end else if ((state_q == ST_DONE) && w_st_rd) begin
                                state_q <= ST_IDLE;
                            end
                        end
                        ST_START: state_q <= finish[k] ? ST_DONE : ST_BUSY;
                        ST_BUSY: begin
                            if (finish[k]) begin
                                state_q <= ST_DONE;
                            end
                        end
                    endcase
                    if (w_st_wr) begin
                        ovr_q <= 1'b0;
                    end else if (w_cmd_wr && ((state_q == ST_START) || (state_q == ST_BUSY))) begin
                        ovr_q <= 1'b1;
                    end
                end
            end

            assign w_busy[k]                   = (state_q == ST_START) || (state_q == ST_BUSY);
            assign w_done[k]                   = (state_q == ST_DONE);
            assign w_ovr[k]                    = ovr_q;
            assign start[k]                    = start_q;
            assign w_ch_data[k]                = data_q;
            assign data[k*DATA_W +: DATA_W]    = data_q;
        end
    endgenerate

`ifdef DEVMGR_IRQ_EN
    logic            w_hit_mask;
    logic [N_CH-1:0] mask_q;
    logic            irq_q;

    assign w_hit_mask = w_in_win && (w_off == c_CH_SPAN);
    assign w_hit      = w_hit_ch || w_hit_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (writeIn && w_hit_mask) begin
                mask_q <= dataIn[N_CH-1:0];
            end
            irq_q <= |(w_done & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign w_hit = w_hit_ch;
`endif

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_sel_cmd[i]) begin
                w_rdata = w_rdata | w_ch_data[i];
            end
            if (w_sel_st[i]) begin
                w_rdata = w_rdata | {{(DATA_W-3){1'b0}}, w_ovr[i], w_done[i], w_busy[i]};
            end
        end
`ifdef DEVMGR_IRQ_EN
        if (w_hit_mask) begin
            w_rdata = {{(DATA_W-N_CH){1'b0}}, mask_q};
        end
`endif
    end

    assign writeOut  = writeIn && !w_hit;
    assign readOut   = readIn  && !w_hit;
    assign memOutOut = w_hit ? w_rdata : memOutIn;

endmodule
`default_nettype wire

// File: tb/tb_device_manager_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_device_manager_mc
// Brief    : Scoreboard bench for device_manager_mc (DEVMGR_IRQ_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
module tb_device_manager_mc;

    localparam int K_RD = 0, K_START = 1, K_DATA = 2, K_WO = 3, K_RO = 4, K_IRQ = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         writeIn = 1'b0;
    logic         readIn = 1'b0;
    logic [31:0]  addressIn = '0;
    logic [31:0]  dataIn = '0;
    logic [31:0]  memOutIn = '0;
    logic [3:0]   finish = '0;
    logic         writeOut;
    logic         readOut;
    logic [31:0]  memOutOut;
    logic [127:0] data;
    logic [3:0]   start;
`ifdef DEVMGR_IRQ_EN
    logic         irq;
`endif

    device_manager_mc #(.N_CH(4), .DATA_W(32), .BASE_ADDR(32'h0000_FF80)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .writeIn   (writeIn),
        .readIn    (readIn),
        .addressIn (addressIn),
        .dataIn    (dataIn),
        .memOutIn  (memOutIn),
        .finish    (finish),
        .writeOut  (writeOut),
        .readOut   (readOut),
        .memOutOut (memOutOut),
        .data      (data),
        .start     (start)
`ifdef DEVMGR_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        int          ch;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    exp_t        m_e;
    logic [31:0] m_act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_v(input int kind, input int ch, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.ch   = ch;
        e.val  = v;
        e.nm   = nm;
        sb.push_back(e);
    endfunction

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            case (m_e.kind)
                K_RD:    m_act = memOutOut;
                K_START: m_act = {28'b0, start};
                K_DATA:  m_act = data[m_e.ch*32 +: 32];
                K_WO:    m_act = {31'b0, writeOut};
                K_RO:    m_act = {31'b0, readOut};
`ifdef DEVMGR_IRQ_EN
                K_IRQ:   m_act = {31'b0, irq};
`endif
                default: m_act = 'x;
            endcase
            n_total++;
            if (m_act === m_e.val) n_pass++;
            else $display("FAIL %s: got %h expected %h", m_e.nm, m_act, m_e.val);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        writeIn   = w;
        readIn    = r;
        addressIn = a;
        dataIn    = d;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ev, input string nm);
        bus(1'b0, 1'b1, a, '0);
        expect_v(K_RD, 0, ev, nm);
        step();
        bus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
        bus(1'b1, 1'b0, a, d);
        expect_v(K_WO, 0, 32'd0, nm);
        step();
        bus(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset and idle state
        step();
        expect_v(K_START, 0, 32'h0, "rst_start");
        expect_v(K_DATA, 0, 32'h0, "rst_data0");
        step();
        rst_n = 1'b1;
        rd(32'hFF84, 32'h0, "idle_st0");
        bus(1'b0, 1'b1, 32'd5, '0);
        memOutIn = 32'd3;
        expect_v(K_RO, 0, 32'd1, "pass_readOut");
        expect_v(K_RD, 0, 32'd3, "pass_memOut");
        step();
        bus(1'b0, 1'b0, '0, '0);
        bus(1'b1, 1'b0, 32'h100, 32'h9);
        expect_v(K_WO, 0, 32'd1, "pass_writeOut");
        step();
        bus(1'b0, 1'b0, '0, '0);

        // Basic command on channel 0
        wr(32'hFF80, 32'hA5A5_0001, "cmd0_wo");
        expect_v(K_START, 0, 32'h1, "cmd0_start");
        expect_v(K_DATA, 0, 32'hA5A5_0001, "cmd0_data");
        rd(32'hFF84, 32'h1, "cmd0_busy_start");
        expect_v(K_START, 0, 32'h0, "cmd0_start_off");
        rd(32'hFF84, 32'h1, "cmd0_busy");
        finish = 4'b0001;
        step();
        finish = 4'b0000;
        rd(32'hFF84, 32'h2, "cmd0_done");
        rd(32'hFF84, 32'h0, "cmd0_cleared");

        // Overrun on channel 1
        wr(32'hFF88, 32'h1111_1111, "ovr_wr1");
        step();
        wr(32'hFF88, 32'h2222_2222, "ovr_wr2");
        expect_v(K_DATA, 1, 32'h1111_1111, "ovr_data_kept");
        rd(32'hFF8C, 32'h5, "ovr_busy");
        finish = 4'b0010;
        step();
        finish = 4'b0000;
        bus(1'b1, 1'b1, 32'hFF8C, 32'hFFFF_FFFF);
        expect_v(K_RD, 0, 32'h6, "ovr_done");
        step();
        bus(1'b0, 1'b0, '0, '0);
        rd(32'hFF8C, 32'h2, "ovr_cleared_done_kept");
        rd(32'hFF8C, 32'h0, "ovr_idle");

        // Two channels interleaved
        wr(32'hFF90, 32'h2222_0002, "two_wr2");
        expect_v(K_START, 0, 32'h4, "two_start2");
        wr(32'hFF98, 32'h3333_0003, "two_wr3");
        expect_v(K_START, 0, 32'h8, "two_start3");
        expect_v(K_DATA, 2, 32'h2222_0002, "two_data2");
        expect_v(K_DATA, 3, 32'h3333_0003, "two_data3");
        step();
        finish = 4'b1000;
        step();
        finish = 4'b0000;
        rd(32'hFF9C, 32'h2, "two_st3_done");
        rd(32'hFF94, 32'h1, "two_st2_busy");
        finish = 4'b0100;
        step();
        finish = 4'b0000;
        rd(32'hFF94, 32'h2, "two_st2_done");
        rd(32'hFF9C, 32'h0, "two_st3_idle");
        rd(32'hFF96, 32'h0, "two_st2_idle_unaligned");

        // finish coinciding with a status read in BUSY
        wr(32'hFF80, 32'h0000_BEEF, "sim_wr");
        step();
        finish = 4'b0001;
        rd(32'hFF84, 32'h1, "sim_busy_read");
        finish = 4'b0000;
        rd(32'hFF84, 32'h2, "sim_done_kept");
        rd(32'hFF84, 32'h0, "sim_cleared");

        // finish during START
        wr(32'hFF88, 32'h7, "fst_wr");
        finish = 4'b0010;
        expect_v(K_START, 0, 32'h2, "fst_start");
        expect_v(K_DATA, 1, 32'h7, "fst_data");
        step();
        finish = 4'b0000;
        rd(32'hFF8C, 32'h2, "fst_done");
        rd(32'hFF8C, 32'h0, "fst_idle");

        // Reset asserted during BUSY
        wr(32'hFF90, 32'h1234, "rb_wr");
        step();
        #2;
        rst_n = 1'b0;
        bus(1'b0, 1'b1, 32'h100, '0);
        memOutIn = 32'h55;
        expect_v(K_START, 0, 32'h0, "rb_start");
        expect_v(K_DATA, 2, 32'h0, "rb_data2");
        expect_v(K_DATA, 0, 32'h0, "rb_data0");
        expect_v(K_RO, 0, 32'd1, "rb_pass_ro");
        expect_v(K_RD, 0, 32'h55, "rb_pass_rd");
        step();
        bus(1'b0, 1'b0, '0, '0);
        step();
        rst_n = 1'b1;
        finish = 4'b0100;
        step();
        finish = 4'b0000;
        rd(32'hFF94, 32'h0, "rb_late_finish");

`ifdef DEVMGR_IRQ_EN
        wr(32'hFFA0, 32'h2, "irq_mask_wr");
        rd(32'hFFA0, 32'h2, "irq_mask_rd");
        wr(32'hFF80, 32'h1, "irq_wr0");
        wr(32'hFF88, 32'h2, "irq_wr1");
        step();
        finish = 4'b0001;
        expect_v(K_IRQ, 0, 32'd0, "irq_pre");
        step();
        finish = 4'b0000;
        expect_v(K_IRQ, 0, 32'd0, "irq_f0_a");
        step();
        expect_v(K_IRQ, 0, 32'd0, "irq_f0_b");
        finish = 4'b0010;
        step();
        finish = 4'b0000;
        expect_v(K_IRQ, 0, 32'd0, "irq_f1_lag");
        step();
        expect_v(K_IRQ, 0, 32'd1, "irq_f1_set");
        rd(32'hFF8C, 32'h2, "irq_st1");
        expect_v(K_IRQ, 0, 32'd1, "irq_clear_lag");
        step();
        expect_v(K_IRQ, 0, 32'd0, "irq_cleared");
        rd(32'hFF84, 32'h2, "irq_st0");
`else
        bus(1'b0, 1'b1, 32'hFFA0, '0);
        memOutIn = 32'hCAFE;
        expect_v(K_RD, 0, 32'hCAFE, "nomask_rd");
        expect_v(K_RO, 0, 32'd1, "nomask_ro");
        step();
        bus(1'b0, 1'b0, '0, '0);
`endif

        repeat (3) step();
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/device_manager_mc.md
# device_manager_mc

Memory-mapped, multi-channel I/O front end between the processor's data-memory port and `N_CH` external devices. Each channel owns a command/data register and a status register in a reserved address window. A write to a channel's command address latches the operand, fires a one-cycle `start`, and tracks the device until its `finish` pulse. All other addresses pass straight through to data memory.

## Interface
Parameters:
- `N_CH`, 4: number of device channels, 1..16.
- `DATA_W`, 32: data and address width.
- `BASE_ADDR`, 32'h0000_FF80: window base, 8-byte aligned.
  - Channel k command address is `BASE_ADDR + 8k`.
  - Channel k status address is `BASE_ADDR + 8k + 4`.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `writeIn` in 1: CPU write strobe.
- `readIn` in 1: CPU read strobe.
- `addressIn` in DATA_W: CPU address.
- `dataIn` in DATA_W: CPU write data.
- `memOutIn` in DATA_W: read data from data memory.
- `finish` in N_CH: per-channel completion pulse from the device.
- `writeOut` out 1: write strobe to data memory.
- `readOut` out 1: read strobe to data memory.
- `memOutOut` out DATA_W: read data returned to the CPU.
- `data` out N_CH*DATA_W: latched operand per channel; channel k occupies bits [k*DATA_W +: DATA_W].
- `start` out N_CH: one-cycle start pulse per channel.
- `irq` out 1: present only with `DEVMGR_IRQ_EN`.

## Operation
Address decode (combinational):
- Hit means `addressIn` is inside [BASE_ADDR, BASE_ADDR + 8*N_CH).
- On a miss: `writeOut = writeIn`, `readOut = readIn`, `memOutOut = memOutIn`.
- On a hit: `writeOut = readOut = 0`.
  - Command address: `memOutOut = data[k]`.
  - Status address: `memOutOut = {29'b0, ovr, done, busy}` for channel k.
- Address bits [1:0] are ignored.

Per-channel FSM. States are IDLE, START, BUSY, DONE.
- IDLE or DONE, write to command address: latch `dataIn` into `data[k]`, clear `done`, go to START.
- START: `start[k] = 1` for exactly this one cycle, then go to BUSY. `busy = 1`.
- BUSY: wait for `finish[k]`, then go to DONE. `busy = 1`.
- DONE: `done = 1`.
  - A read of the status address goes to IDLE; the clear is applied on that clock edge.
  - The read data returned in that same cycle still shows done=1.
- A write to the command address in START or BUSY is dropped: `data[k]` is unchanged, the state is unchanged, and `ovr` is set.
- `ovr` is sticky. It clears only on a CPU write to the status address, whatever the write data, or on reset.
- `finish[k]` in IDLE or DONE is ignored.
- `finish[k]` in START is accepted: the next state is DONE, and `start` still pulses that cycle.

Simultaneous events:
- `finish` and a status read in the same cycle in BUSY: the next state is DONE, and `done` is not cleared.
- A command write to channel k and a `finish[j]` with j≠k are fully independent.
- Only one address is decoded per cycle; `readIn` and `writeIn` together on a hit execute the write side effects only.

## Timing
- Command write sampled at edge T: `start[k]` is high for T..T+1, and `data[k]` is valid from T onward.
- `finish[k]` sampled at edge T: status reads done=1 from T onward.
- Decode, passthrough and `memOutOut` are combinational, with zero latency.
- Reset (`rst_n = 0`, asynchronous): all channels go to IDLE.
  - `data`, `start`, `ovr`, `done` and `irq` are all 0.
  - Passthrough outputs follow their inputs as on a miss.
  - Reset in the middle of BUSY drops the operation; a late `finish` after reset is ignored.

## Configuration
- `DEVMGR_IRQ_EN` defined:
  - Adds an `N_CH`-bit mask register at `BASE_ADDR + 8*N_CH`. It is written from `dataIn[N_CH-1:0]`, read back zero-extended, and resets to 0. The hit window extends by 4 bytes.
  - `irq` is registered: `irq = |(done_vec & mask)`, updated on each edge.
- Not defined:
  - No `irq` port and no mask register.
  - `BASE_ADDR + 8*N_CH` decodes as a miss (passthrough).

## Test plan
- Reset, then check idle outputs: `start = 0`, `data = 0`; a read of the channel-0 status address returns 0; `addressIn = 5`, `readIn = 1`, `memOutIn = 3` gives `readOut = 1` and `memOutOut = 3`.
- Basic command on channel 0: write 32'hA5A5_0001 to 0xFF80, then 1-cycle `start[0]`; status 0xFF84 reads 1; pulse `finish[0]`; status reads 2, then reads 0 on the next read.
- Overrun: a second write to 0xFF88 while channel 1 is busy leaves `data[1]` unchanged and status reads 5 (busy plus ovr); after `finish` status reads 6; a write to 0xFF8C then reads 2.
- Two channels: commands to channels 2 and 3 on consecutive cycles, with `finish[3]` before `finish[2]`; each status reflects only its own channel.
- Boundary events:
  - `finish` and a status read in the same cycle gives done=1 on the following read.
  - `finish` during START gives DONE.
  - `rst_n` low during BUSY returns all to zero.
- With `DEVMGR_IRQ_EN` defined: mask = 4'b0010; `finish[0]` keeps `irq` at 0; `finish[1]` gives `irq` = 1 one cycle later; a status read of channel 1 returns `irq` to 0.
